// File: rtl/led_fade_driver.sv
// led_fade_driver
// Soft on/off LED driver. A level request from the blink stage ramps the PWM
// duty up to a runtime ceiling (brightness_max) and back down to zero, one
// duty step every RAMP_DIV clocks. The working duty is copied into the PWM
// comparator only at the end of a PWM period, so no period is ever cut short
// or stretched.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   S_OFF  | LED dark, duty held at 0, waiting for led_req
//   S_UP   | ramping duty towards brightness_max
//   S_ON   | fully on, duty tracks brightness_max every cycle
//   S_DOWN | ramping duty towards 0 (ceiling ignored)

module led_fade_driver #(
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_req,
  input  logic [PWM_BITS-1:0] brightness_max,
  output logic                LED,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam int STEP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                busy_q, busy_d;
  logic [PWM_BITS-1:0] duty_active_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                led_q;
  logic                step_tick;

  assign step_tick = (step_cnt_q == STEP_LAST);

  // Next-state, duty and step-timer logic; led_req is examined before the
  // ramp so a reversal always wins over a pending step.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    step_cnt_d = '0;

    case (state_q)
      S_OFF: begin
        duty_d = '0;
        if (led_req) begin
          state_d = S_UP;
        end
      end

      S_UP: begin
        if (!led_req) begin
          state_d = S_DOWN;
        end else if (duty_q >= brightness_max) begin
          state_d = S_ON;
          duty_d  = brightness_max;
        end else begin
          step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
          if (step_tick) begin
            duty_d = duty_q + 1'b1;
          end
        end
      end

      S_ON: begin
        duty_d = brightness_max;
        if (!led_req) begin
          state_d = S_DOWN;
        end
      end

      S_DOWN: begin
        if (led_req) begin
          state_d = S_UP;
        end else if (duty_q == '0) begin
          state_d = S_OFF;
        end else begin
          step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
          if (step_tick) begin
            duty_d = duty_q - 1'b1;
          end
        end
      end

      default: begin
        state_d = S_OFF;
        duty_d  = '0;
      end
    endcase

    busy_d = (state_d == S_UP) || (state_d == S_DOWN);
  end

  // State, duty, step timer and busy flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OFF;
      duty_q     <= '0;
      step_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      step_cnt_q <= step_cnt_d;
      busy_q     <= busy_d;
    end
  end

  // Free-running PWM counter; duty shadow reloads only at the period end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q     <= '0;
      duty_active_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      if (pwm_cnt_q == PWM_LAST) begin
        duty_active_q <= duty_q;
      end
    end
  end

  // Registered PWM compare driving the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= (pwm_cnt_q < duty_active_q);
    end
  end

  assign LED  = led_q;
  assign duty = duty_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with PWM_BITS=4, RAMP_DIV=4.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// pwm_m tracks the DUT's free-running PWM counter (0 at reset release).

module tb_led_fade_driver;

  logic       clk;
  logic       rst_n;
  logic       led_req;
  logic [3:0] brightness_max;
  logic       LED;
  logic [3:0] duty;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int pwm_m = 0;
  int n;
  int highs;

  led_fade_driver #(
    .PWM_BITS(4),
    .RAMP_DIV(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .led_req       (led_req),
    .brightness_max(brightness_max),
    .LED           (LED),
    .duty          (duty),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pwm_m = (pwm_m + 1) % 16;
  endtask

  task automatic count_led(input int cycles, output int h);
    h = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (LED === 1'b1) h++;
    end
  endtask

  task automatic wait_idle(input int max_cyc, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (busy !== 1'b0 && cnt < max_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    led_req        = 1'b0;
    brightness_max = 4'd15;
    #2;
    chk("rst_led", LED, 0);
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    #10;
    rst_n = 1'b1;
    pwm_m = 0;

    // OFF: pin dark for several PWM periods
    count_led(64, highs);
    chk("off_led_highs", highs, 0);
    chk("off_busy", busy, 0);

    // Ramp up to 15: one step per 4 clocks
    led_req = 1'b1;
    tick();
    chk("up_entry_busy", busy, 1);
    chk("up_entry_duty", duty, 0);
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk($sformatf("up_duty_k%0d", k), duty, k / 4);
      chk($sformatf("up_busy_k%0d", k), busy, 1);
    end
    tick();
    chk("on_busy", busy, 0);
    chk("on_duty", duty, 15);

    // ON at 15: LED high 15 of every 16 clocks once the shadow has reloaded
    repeat (32) tick();
    count_led(16, highs);
    chk("on15_highs", highs, 15);

    // Full ramp down from 15
    led_req = 1'b0;
    wait_idle(100, n);
    chk("down15_len", n, 62);
    chk("down15_duty", duty, 0);

    // Reversal at duty 6
    led_req = 1'b1;
    tick();
    repeat (24) tick();
    chk("rev_duty6", duty, 6);
    led_req = 1'b0;
    tick();
    chk("rev_down_busy", busy, 1);
    chk("rev_down_duty", duty, 6);
    repeat (3) tick();
    chk("rev_duty_still6", duty, 6);
    tick();
    chk("rev_duty5", duty, 5);
    repeat (20) tick();
    chk("rev_duty0", duty, 0);
    chk("rev_busy_at0", busy, 1);
    tick();
    chk("rev_off_busy", busy, 0);
    chk("rev_off_duty", duty, 0);

    // Ceiling change in ON: 8 -> 3
    brightness_max = 4'd8;
    led_req        = 1'b1;
    wait_idle(100, n);
    chk("up8_len", n, 34);
    chk("up8_duty", duty, 8);
    repeat (32) tick();
    count_led(16, highs);
    chk("on8_highs", highs, 8);
    n = 0;
    while (pwm_m != 5 && n < 20) begin
      tick();
      n++;
    end
    chk("align_pwm5", pwm_m, 5);
    brightness_max = 4'd3;
    tick();
    chk("ceil_duty3", duty, 3);
    chk("ceil_old_active_p6", LED, 1);
    tick();
    tick();
    chk("ceil_old_active_p8", LED, 1);
    n = 0;
    while (pwm_m != 0 && n < 20) begin
      tick();
      n++;
    end
    count_led(16, highs);
    chk("on3_highs", highs, 3);

    // Down from 3, then zero ceiling
    led_req = 1'b0;
    wait_idle(100, n);
    chk("down3_len", n, 14);
    brightness_max = 4'd0;
    led_req        = 1'b1;
    tick();
    chk("zero_up_busy", busy, 1);
    tick();
    chk("zero_on_busy", busy, 0);
    chk("zero_on_duty", duty, 0);
    count_led(32, highs);
    chk("zero_led_highs", highs, 0);
    led_req = 1'b0;
    tick();
    chk("zero_down_busy", busy, 1);
    tick();
    chk("zero_off_busy", busy, 0);

    // Toggling request holds duty; step timer restarts on each entry
    brightness_max = 4'd15;
    led_req        = 1'b1;
    tick();
    repeat (8) tick();
    chk("tog_start_duty2", duty, 2);
    for (int i = 0; i < 10; i++) begin
      led_req = ~led_req;
      tick();
      chk($sformatf("tog_duty_%0d", i), duty, 2);
      chk($sformatf("tog_busy_%0d", i), busy, 1);
    end
    repeat (3) tick();
    chk("tog_after3_duty2", duty, 2);
    tick();
    chk("tog_after4_duty3", duty, 3);
    repeat (16) tick();
    chk("pre_rst_duty7", duty, 7);

    // Asynchronous reset mid-ramp
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_led", LED, 0);
    chk("arst_duty", duty, 0);
    chk("arst_busy", busy, 0);
    led_req = 1'b0;
    #2;
    rst_n = 1'b1;
    pwm_m = 0;
    count_led(20, highs);
    chk("post_rst_highs", highs, 0);
    chk("post_rst_duty", duty, 0);
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
